// File: rtl/shifter_tx.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : shifter_tx                                            |
// | Purpose  : parallel-in, LSB-first serial-out transmitter with    |
// |            valid/ready load and zero-gap back-to-back framing.   |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
module shifter_tx #(
  parameter int   WIDTH    = 8,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic             clock,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             frame_start,
  output logic             frame_done
);

  localparam int                c_cnt_w    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(WIDTH - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
  localparam logic [c_cnt_w-1:0] c_cnt_zero = '0;

  localparam logic [0:0] c_st_idle  = 1'b0;
  localparam logic [0:0] c_st_shift = 1'b1;

  logic [0:0]         r_state;
  logic [0:0]         w_state_next;
  logic [WIDTH-1:0]   r_sreg;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_serial_out;
  logic               r_serial_valid;
  logic               w_last;
  logic               w_accept;

  assign w_last   = (r_state == c_st_shift) && (r_cnt == c_last_cnt);
  assign w_accept = load_valid && load_ready;

  // State register; reset has priority over any simultaneous load.
  always_ff @(posedge clock) begin
    if (rst) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_st_idle: begin
        if (w_accept) begin
          w_state_next = c_st_shift;
        end
      end
      c_st_shift: begin
        if (w_last) begin
          w_state_next = w_accept ? c_st_shift : c_st_idle;
        end
      end
      default: w_state_next = c_st_idle;
    endcase
  end

  // Output logic: ready in IDLE and on the last bit, so a new word
  // can follow the previous one without an idle cycle.
  always_comb begin
    load_ready  = (r_state == c_st_idle) || w_last;
    frame_start = r_serial_valid && (r_cnt == c_cnt_zero);
    frame_done  = r_serial_valid && (r_cnt == c_last_cnt);
  end

  // Datapath: bit 0 goes straight to the line on accept, the rest
  // waits in the shift register.
  always_ff @(posedge clock) begin
    if (rst) begin
      r_sreg         <= '0;
      r_cnt          <= c_cnt_zero;
      r_serial_out   <= IDLE_BIT;
      r_serial_valid <= 1'b0;
    end else if (w_accept) begin
      r_serial_out   <= data_in[0];
      r_sreg         <= data_in >> 1;
      r_cnt          <= c_cnt_zero;
      r_serial_valid <= 1'b1;
    end else if (r_state == c_st_shift) begin
      if (w_last) begin
        r_serial_out   <= IDLE_BIT;
        r_serial_valid <= 1'b0;
        r_cnt          <= c_cnt_zero;
      end else begin
        r_serial_out <= r_sreg[0];
        r_sreg       <= r_sreg >> 1;
        r_cnt        <= r_cnt + c_cnt_one;
      end
    end
  end

  assign serial_out   = r_serial_out;
  assign serial_valid = r_serial_valid;

endmodule
`default_nettype wire

// File: tb/tb_shifter_tx.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : tb_shifter_tx                                         |
// | Purpose  : directed + random bench for shifter_tx with a frame-  |
// |            level reference model and a loopback receiver model.  |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
module tb_shifter_tx;

  localparam int   WIDTH    = 8;
  localparam logic IDLE_BIT = 1'b0;

  logic             clock;
  logic             rst;
  logic [WIDTH-1:0] data_in;
  logic             load_valid;
  logic             load_ready;
  logic             serial_out;
  logic             serial_valid;
  logic             frame_start;
  logic             frame_done;

  int checks = 0;
  int errors = 0;

  // Reference model: which word is on the line and which bit of it.
  logic             m_active = 1'b0;
  int               m_idx    = 0;
  logic [WIDTH-1:0] m_word   = '0;
  // Receiver model: shift right, new bit enters at the MSB.
  logic [WIDTH-1:0] rx       = '0;

  shifter_tx #(.WIDTH(WIDTH), .IDLE_BIT(IDLE_BIT)) dut (
    .clock        (clock),
    .rst          (rst),
    .data_in      (data_in),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .serial_out   (serial_out),
    .serial_valid (serial_valid),
    .frame_start  (frame_start),
    .frame_done   (frame_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                       input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic m_ready();
    return !m_active || (m_idx == WIDTH - 1);
  endfunction

  task automatic check_outputs();
    logic eb;
    eb = m_active ? m_word[m_idx] : IDLE_BIT;
    check("serial_out",   {{(WIDTH-1){1'b0}}, serial_out},   {{(WIDTH-1){1'b0}}, eb});
    check("serial_valid", {{(WIDTH-1){1'b0}}, serial_valid}, {{(WIDTH-1){1'b0}}, m_active});
    check("frame_start",  {{(WIDTH-1){1'b0}}, frame_start},
          {{(WIDTH-1){1'b0}}, m_active && m_idx == 0});
    check("frame_done",   {{(WIDTH-1){1'b0}}, frame_done},
          {{(WIDTH-1){1'b0}}, m_active && m_idx == WIDTH - 1});
    check("load_ready",   {{(WIDTH-1){1'b0}}, load_ready},   {{(WIDTH-1){1'b0}}, m_ready()});
  endtask

  // One clock: drive inputs, advance the model at the edge, check after.
  task automatic step(input logic r, input logic v, input logic [WIDTH-1:0] d);
    logic             acc;
    logic             line_bit;
    logic             was_done;
    logic [WIDTH-1:0] sent_word;
    rst        = r;
    load_valid = v;
    data_in    = d;
    acc        = !r && v && m_ready();
    line_bit   = serial_out;
    was_done   = m_active && (m_idx == WIDTH - 1);
    sent_word  = m_word;
    @(posedge clock);
    rx = {line_bit, rx[WIDTH-1:1]};
    if (r) begin
      m_active = 1'b0;
    end else if (acc) begin
      m_active = 1'b1;
      m_idx    = 0;
      m_word   = d;
    end else if (m_active) begin
      if (m_idx == WIDTH - 1) m_active = 1'b0;
      else m_idx++;
    end
    #1;
    if (was_done) check("loopback_word", rx, sent_word);
    check_outputs();
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, $urandom);
  endtask

  initial begin
    rst        = 1'b1;
    load_valid = 1'b0;
    data_in    = '0;
    @(negedge clock);

    // Reset held with a load request present; nothing may be taken.
    step(1'b1, 1'b1, 8'hFF);
    step(1'b1, 1'b1, 8'hFF);
    check("reset_serial_out", {{(WIDTH-1){1'b0}}, serial_out}, '0);
    idle_cycles(3);

    // Single word 0xA5.
    step(1'b0, 1'b1, 8'hA5);
    idle_cycles(WIDTH + 1);

    // Back-to-back 0x3C then 0xC3 with load_valid held.
    step(1'b0, 1'b1, 8'h3C);
    for (int i = 0; i < WIDTH - 1; i++) step(1'b0, 1'b1, 8'hC3);
    step(1'b0, 1'b1, 8'hC3);
    idle_cycles(WIDTH + 1);

    // Load pulse while busy must be ignored.
    step(1'b0, 1'b1, 8'h0F);
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'hF0);
    idle_cycles(WIDTH);

    // Reset after 3 bits of 0x81, then a clean 0xFF frame.
    step(1'b0, 1'b1, 8'h81);
    idle_cycles(2);
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'hFF);
    idle_cycles(WIDTH + 1);

    // Loopback word 0x5A.
    step(1'b0, 1'b1, 8'h5A);
    idle_cycles(WIDTH + 1);

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 2) != 0),
           WIDTH'($urandom));
    end
    idle_cycles(WIDTH + 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
